xor_gate: RTL and testbench
===========================

// Module: xor_gate
// PURPOSE
//  Bitwise XOR of two operand vectors. Provides a combinational result (y) plus
//  a one-cycle registered copy with valid flag, parity and popcount of the result.
//  Generic logic primitive for datapath, comparison and checksum blocks.
//  The combinational path is usable without clocking: tie clk low and rst_n high.
// PARAMETERS
//  WIDTH   1   operand/result width in bits (>=1)
//  CNT_W   16  width of the optional statistics counter
// PORTS
//  clk        in   1                    rising-edge clock (single clock domain)
//  rst_n      in   1                    asynchronous active-low reset
//  in_valid   in   1                    qualifies a/b for the registered stage
//  a          in   WIDTH                operand A
//  b          in   WIDTH                operand B
//  y          out  WIDTH                combinational a ^ b
//  out_valid  out  1                    registered result is valid this cycle
//  y_q        out  WIDTH                registered a ^ b
//  parity_q   out  1                    registered ^(a ^ b), i.e. XOR-reduce of result
//  ones_q     out  $clog2(WIDTH+1)      registered count of 1-bits in a ^ b
//  stat_cnt   out  CNT_W                only when XOR_GATE_STATS_EN is defined
// BEHAVIOUR
//  - y = a ^ b at all times, zero latency, independent of clk/rst_n/in_valid.
//  - Registered outputs change only on posedge clk or on reset assertion.
//  - Reset (rst_n=0, async, immediate): out_valid=0, y_q=0, parity_q=0, ones_q=0,
//    stat_cnt=0. Released synchronously: first capture at the first posedge after rst_n=1.
//  - Each posedge: out_valid <= in_valid.
//  - posedge with in_valid=1: y_q <= a^b; parity_q <= ^(a^b); ones_q <= popcount(a^b).
//  - posedge with in_valid=0: y_q/parity_q/ones_q hold their previous values.
//  - Latency in_valid -> out_valid: exactly 1 cycle. No backpressure, no ready.
//    Back-to-back valid every cycle is supported.
//  - X/Z on a or b propagates per Verilog XOR semantics. No sanitising.
//  - ones_q range is 0..WIDTH. WIDTH=1 gives ones_q width 1, and ones_q == y_q.
//  - Reset asserted mid-stream: the in-flight result is discarded, out_valid=0 at once.
// CONFIGURATION
//  - XOR_GATE_STATS_EN defined:
//    stat_cnt port exists. Increments by 1 on each posedge with in_valid=1 and a!=b.
//    Saturates at all-ones and never wraps. Cleared by reset.
//  - XOR_GATE_STATS_EN undefined:
//    stat_cnt port and logic are absent. All other behaviour is identical.
// TESTING
//  - WIDTH=1, no clock, rst_n=1: drive a,b = 00,01,10,11 at 10-time-unit steps.
//    Require y = 0,1,1,0 within each step.
//  - Reset: rst_n=0 mid-cycle, with prior y_q=1 and out_valid=1.
//    Require out_valid=0, y_q=0, parity_q=0, ones_q=0 immediately, not at the clock edge.
//  - WIDTH=8, in_valid=1, a=8'hF0, b=8'h3C.
//    Require y=8'hCC at once; one cycle later out_valid=1, y_q=8'hCC, parity_q=0, ones_q=4.
//  - WIDTH=8, in_valid pulsed 1 then 0, with a,b changed during the low cycle.
//    Require y tracks the new a^b, y_q holds the old value, and out_valid falls after 1 cycle.
//  - WIDTH=8, a=b=8'hA5, in_valid=1.
//    Require y=0, y_q=0, ones_q=0; with XOR_GATE_STATS_EN, stat_cnt unchanged.
//  - XOR_GATE_STATS_EN, CNT_W=2, four valid unequal pairs.
//    Require stat_cnt = 1,2,3,3 (saturates, does not wrap).

Source files
------------

// File: rtl/xor_gate.sv
// xor_gate: bitwise XOR of two operand vectors.
//   y          - combinational a ^ b, independent of clock and reset
//   y_q        - registered copy of a ^ b, captured when in_valid is high
//   out_valid  - in_valid delayed by exactly one cycle
//   parity_q   - registered XOR-reduce of the result
//   ones_q     - registered count of 1-bits in the result
// The optional saturating statistics counter (stat_cnt) is present only
// when the macro XOR_GATE_STATS_EN is defined.
module xor_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16,
  localparam int ONES_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  y,
  output logic              out_valid,
  output logic [WIDTH-1:0]  y_q,
  output logic              parity_q,
  output logic [ONES_W-1:0] ones_q
`ifdef XOR_GATE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_cnt
`endif
);

  // Reject degenerate configurations at elaboration time.
  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_params
    $error("xor_gate: WIDTH and CNT_W must both be at least 1");
  end

  logic [WIDTH-1:0]  diff;
  logic              parity;
  logic [ONES_W-1:0] ones;

  assign diff   = a ^ b;
  assign y      = diff;
  assign parity = ^diff;

  // Population count of the XOR result; the width holds 0..WIDTH exactly.
  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + ONES_W'(diff[i]);
    end
  end

  // Valid flag follows in_valid by one cycle; reset discards in-flight data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

  // Result registers capture only on valid cycles and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q      <= '0;
      parity_q <= 1'b0;
      ones_q   <= '0;
    end else if (in_valid) begin
      y_q      <= diff;
      parity_q <= parity;
      ones_q   <= ones;
    end
  end

`ifdef XOR_GATE_STATS_EN
  // Count valid cycles whose operands differ; stick at all-ones, never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt <= '0;
    end else if (in_valid && (a != b) && (stat_cnt != {CNT_W{1'b1}})) begin
      stat_cnt <= stat_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_xor_gate.sv
// Testbench for xor_gate. A WIDTH=1 instance exercises the unclocked
// combinational path; a WIDTH=8, CNT_W=2 instance exercises the registered
// stage. Registered results are checked by a monitor that pops expected
// values from a scoreboard queue whenever out_valid is seen.
// Build with XOR_GATE_STATS_EN defined to also check stat_cnt.
module tb_xor_gate;

  typedef struct packed {
    logic [7:0] y;
    logic       parity;
    logic [3:0] ones;
  } exp_t;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  // WIDTH=1 instance, never clocked
  logic clk1 = 1'b0;
  logic rst1_n = 1'b0;
  logic a1 = 1'b0, b1 = 1'b0;
  logic in_valid1 = 1'b0;
  logic y1, out_valid1, y_q1, parity_q1;
  logic ones_q1;

  // WIDTH=8 instance
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic [7:0] y, y_q;
  logic out_valid, parity_q;
  logic [3:0] ones_q;

  int exp_stat = 0;

`ifdef XOR_GATE_STATS_EN
  logic [15:0] stat_cnt1;
  logic [1:0]  stat_cnt;
`endif

  xor_gate #(.WIDTH(1)) u_w1 (
    .clk(clk1), .rst_n(rst1_n), .in_valid(in_valid1), .a(a1), .b(b1),
    .y(y1), .out_valid(out_valid1), .y_q(y_q1), .parity_q(parity_q1),
    .ones_q(ones_q1)
`ifdef XOR_GATE_STATS_EN
    , .stat_cnt(stat_cnt1)
`endif
  );

  xor_gate #(.WIDTH(8), .CNT_W(2)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .y(y), .out_valid(out_valid), .y_q(y_q), .parity_q(parity_q),
    .ones_q(ones_q)
`ifdef XOR_GATE_STATS_EN
    , .stat_cnt(stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // One cycle of stimulus: drive at negedge, check y at once, push expected
  // registered result when valid, then check the stats model after the edge.
  task automatic step(input logic v, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] ey, input logic ep, input logic [3:0] eo);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    a = av;
    b = bv;
    if (v) begin
      e.y = ey;
      e.parity = ep;
      e.ones = eo;
      sb.push_back(e);
    end
    #1;
    check("y_comb", 64'(y), 64'(ey));
    @(posedge clk);
    #1;
    if (v && (av != bv) && exp_stat != 3) exp_stat++;
`ifdef XOR_GATE_STATS_EN
    check("stat_cnt", 64'(stat_cnt), 64'(exp_stat));
`endif
  endtask

  // Monitor: compare registered outputs against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: out_valid=1 with no expected entry");
        end else begin
          e = sb.pop_front();
          check("y_q", 64'(y_q), 64'(e.y));
          check("parity_q", 64'(parity_q), 64'(e.parity));
          check("ones_q", 64'(ones_q), 64'(e.ones));
        end
      end
    end
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] ab;
    logic [3:0] exp_y1;
    exp_y1 = 4'b0110;

    // WIDTH=1 combinational path, no clock.
    #1 rst1_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a1 = ab[1];
      b1 = ab[0];
      #5;
      check($sformatf("w1_y_%0d", i), 64'(y1), 64'(exp_y1[i]));
      #5;
    end
    check("w1_out_valid_idle", 64'(out_valid1), 64'd0);
    check("w1_y_q_idle", 64'(y_q1), 64'd0);
    check("w1_regs_idle", 64'({parity_q1, ones_q1}), 64'd0);

    // WIDTH=8: hold reset, then release at a negedge.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y_q", 64'(y_q), 64'd0);
    check("rst_parity_ones", 64'({parity_q, ones_q}), 64'd0);
    rst_n = 1'b1;

    // F0 ^ 3C = CC, 4 ones, even parity.
    step(1'b1, 8'hF0, 8'h3C, 8'hCC, 1'b0, 4'd4);
    // in_valid low with new operands: y tracks, y_q holds.
    step(1'b0, 8'h12, 8'h34, 8'h26, 1'b0, 4'd0);
    check("hold_y_q", 64'(y_q), 64'hCC);
    check("out_valid_fall", 64'(out_valid), 64'd0);
    // Equal operands: zero result, stats unchanged.
    step(1'b1, 8'hA5, 8'hA5, 8'h00, 1'b0, 4'd0);
    // Back-to-back valid cycles (stats saturate at 3 along the way).
    step(1'b1, 8'hFF, 8'h00, 8'hFF, 1'b0, 4'd8);
    step(1'b1, 8'h0F, 8'h01, 8'h0E, 1'b1, 4'd3);
    step(1'b1, 8'h55, 8'h00, 8'h55, 1'b0, 4'd4);
    step(1'b1, 8'h01, 8'h00, 8'h01, 1'b1, 4'd1);

    // Mid-cycle reset with y_q=1 and out_valid=1 present.
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    check("pre_rst_y_q", 64'(y_q), 64'h01);
    rst_n = 1'b0;
    exp_stat = 0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_y_q", 64'(y_q), 64'd0);
    check("async_rst_parity_ones", 64'({parity_q, ones_q}), 64'd0);
`ifdef XOR_GATE_STATS_EN
    check("async_rst_stat", 64'(stat_cnt), 64'd0);
`endif
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // First capture after release.
    step(1'b1, 8'h80, 8'h7F, 8'hFF, 1'b0, 4'd8);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
